// File: rtl/store_merge_unit.sv
// store_merge_unit: turns sb/sh/sw requests into full-word memory writes.
// Sub-word stores read the target word, merge the new lane(s), then write.
module store_merge_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        store_req,
    input  logic [31:0] addr,
    input  logic [2:0]  funct3,
    input  logic [31:0] write_data,
    output logic        busy,
    output logic        done,
    output logic        misaligned_err,
    output logic [31:0] mem_addr,
    output logic        mem_rd_en,
    input  logic [31:0] mem_rdata,
    output logic        mem_wr_en,
    output logic [31:0] mem_wdata
);

    localparam logic [2:0] F3_SB = 3'b000;
    localparam logic [2:0] F3_SH = 3'b001;
    localparam logic [2:0] F3_SW = 3'b010;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        MERGE,
        WRITE
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] merged_q;
    logic [2:0]  funct3_q;
    logic        err_q;
    logic        legal;
    logic        accept;
    logic        reject;
    logic [31:0] merge_word;

    always_comb begin
        legal = 1'b0;
        case (funct3)
            F3_SB:   legal = 1'b1;
            F3_SH:   legal = ~addr[0];
            F3_SW:   legal = (addr[1:0] == 2'b00);
            default: legal = 1'b0;
        endcase
    end

    assign accept = (state == IDLE) && store_req && legal;
    assign reject = (state == IDLE) && store_req && !legal;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        mem_rd_en = 1'b0;
        mem_wr_en = 1'b0;
        unique case (state)
            IDLE: begin
                if (accept)
                    state_nxt = (funct3 == F3_SW) ? WRITE : READ;
            end
            READ: begin
                busy      = 1'b1;
                mem_rd_en = 1'b1;
                state_nxt = MERGE;
            end
            MERGE: begin
                busy      = 1'b1;
                state_nxt = WRITE;
            end
            WRITE: begin
                busy      = 1'b1;
                mem_wr_en = 1'b1;
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Lane positions come from the latched address, not the live port
    always_comb begin
        merge_word = mem_rdata;
        if (funct3_q == F3_SH)
            merge_word[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
        else
            merge_word[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q   <= '0;
            wdata_q  <= '0;
            merged_q <= '0;
            funct3_q <= '0;
            err_q    <= 1'b0;
        end else begin
            err_q <= reject;
            if (accept) begin
                addr_q   <= addr;
                funct3_q <= funct3;
                wdata_q  <= write_data;
            end
            if (state == MERGE)
                merged_q <= merge_word;
        end
    end

    assign misaligned_err = err_q;
    assign mem_addr  = busy ? {addr_q[31:2], 2'b00} : '0;
    assign mem_wdata = !mem_wr_en ? '0 :
                       (funct3_q == F3_SW) ? wdata_q : merged_q;

endmodule

// File: tb/tb_store_merge_unit.sv
// tb_store_merge_unit: directed checks of store_merge_unit against
// hand-computed merge results and cycle-accurate strobe timing.
module tb_store_merge_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        store_req;
    logic [31:0] addr;
    logic [2:0]  funct3;
    logic [31:0] write_data;
    logic        busy;
    logic        done;
    logic        misaligned_err;
    logic [31:0] mem_addr;
    logic        mem_rd_en;
    logic [31:0] mem_rdata;
    logic        mem_wr_en;
    logic [31:0] mem_wdata;

    logic [31:0] mem_word;
    int          wr_count = 0;
    int          total = 0;
    int          passed = 0;

    store_merge_unit dut (
        .clk            (clk),
        .reset          (reset),
        .store_req      (store_req),
        .addr           (addr),
        .funct3         (funct3),
        .write_data     (write_data),
        .busy           (busy),
        .done           (done),
        .misaligned_err (misaligned_err),
        .mem_addr       (mem_addr),
        .mem_rd_en      (mem_rd_en),
        .mem_rdata      (mem_rdata),
        .mem_wr_en      (mem_wr_en),
        .mem_wdata      (mem_wdata)
    );

    always #5 clk = ~clk;

    // Single-word memory with 1-cycle synchronous read
    always @(posedge clk) begin
        if (mem_rd_en) mem_rdata <= mem_word;
        if (mem_wr_en) wr_count <= wr_count + 1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    endtask

    task automatic idle_outputs(input string tag);
        chk1({tag, "_busy"}, busy, 1'b0);
        chk1({tag, "_done"}, done, 1'b0);
        chk1({tag, "_rd"}, mem_rd_en, 1'b0);
        chk1({tag, "_wr"}, mem_wr_en, 1'b0);
        chk32({tag, "_addr"}, mem_addr, 32'h0);
        chk32({tag, "_wdata"}, mem_wdata, 32'h0);
    endtask

    task automatic sub_store(input string tag, input logic [31:0] a,
                             input logic [2:0] f3, input logic [31:0] wd,
                             input logic [31:0] exp);
        addr = a; funct3 = f3; write_data = wd; store_req = 1'b1;
        step();
        store_req = 1'b0;
        chk1({tag, "_c1_rd"}, mem_rd_en, 1'b1);
        chk1({tag, "_c1_wr"}, mem_wr_en, 1'b0);
        chk1({tag, "_c1_busy"}, busy, 1'b1);
        chk32({tag, "_c1_addr"}, mem_addr, {a[31:2], 2'b00});
        step();
        chk1({tag, "_c2_rd"}, mem_rd_en, 1'b0);
        chk1({tag, "_c2_wr"}, mem_wr_en, 1'b0);
        chk1({tag, "_c2_busy"}, busy, 1'b1);
        step();
        chk1({tag, "_c3_wr"}, mem_wr_en, 1'b1);
        chk1({tag, "_c3_done"}, done, 1'b1);
        chk1({tag, "_c3_rd"}, mem_rd_en, 1'b0);
        chk32({tag, "_c3_addr"}, mem_addr, {a[31:2], 2'b00});
        chk32({tag, "_c3_wdata"}, mem_wdata, exp);
        step();
        idle_outputs({tag, "_c4"});
    endtask

    task automatic reject_case(input string tag, input logic [31:0] a,
                               input logic [2:0] f3);
        addr = a; funct3 = f3; write_data = 32'h12345678; store_req = 1'b1;
        step();
        store_req = 1'b0;
        chk1({tag, "_err"}, misaligned_err, 1'b1);
        idle_outputs({tag, "_c1"});
        step();
        chk1({tag, "_err_c2"}, misaligned_err, 1'b0);
        idle_outputs({tag, "_c2"});
    endtask

    logic [31:0] sb_exp [4];
    int          base;

    initial begin
        sb_exp[0] = 32'h112233AB;
        sb_exp[1] = 32'h1122AB44;
        sb_exp[2] = 32'h11AB3344;
        sb_exp[3] = 32'hAB223344;

        reset = 1'b1; store_req = 1'b0; addr = '0; funct3 = '0;
        write_data = '0; mem_word = '0;
        step();
        step();
        idle_outputs("reset");
        chk1("reset_err", misaligned_err, 1'b0);
        reset = 1'b0;
        step();

        // sw aligned
        addr = 32'h100; funct3 = 3'b010; write_data = 32'hDEADBEEF;
        store_req = 1'b1;
        step();
        store_req = 1'b0;
        chk1("sw_c1_wr", mem_wr_en, 1'b1);
        chk1("sw_c1_done", done, 1'b1);
        chk1("sw_c1_busy", busy, 1'b1);
        chk1("sw_c1_rd", mem_rd_en, 1'b0);
        chk32("sw_c1_addr", mem_addr, 32'h100);
        chk32("sw_c1_wdata", mem_wdata, 32'hDEADBEEF);
        step();
        idle_outputs("sw_c2");

        // sb, all lanes
        mem_word = 32'h11223344;
        for (int i = 0; i < 4; i++)
            sub_store($sformatf("sb_lane%0d", i), 32'h200 + i, 3'b000,
                      32'hFFFFFFAB, sb_exp[i]);

        // sh, both halves
        mem_word = 32'hAABBCCDD;
        sub_store("sh_lo", 32'h300, 3'b001, 32'h00001234, 32'hAABB1234);
        sub_store("sh_hi", 32'h302, 3'b001, 32'h00001234, 32'h1234CCDD);

        // rejections
        reject_case("rej_sh", 32'h301, 3'b001);
        reject_case("rej_sw", 32'h402, 3'b010);
        reject_case("rej_f3", 32'h400, 3'b011);

        // request held across an sb
        mem_word = 32'h11223344;
        base = wr_count;
        addr = 32'h201; funct3 = 3'b000; write_data = 32'h000000AB;
        store_req = 1'b1;
        step();
        chk1("hold_c1_rd", mem_rd_en, 1'b1);
        step();
        chk1("hold_c2_rd", mem_rd_en, 1'b0);
        step();
        chk1("hold_c3_wr", mem_wr_en, 1'b1);
        chk32("hold_c3_wdata", mem_wdata, 32'h1122AB44);
        step();
        chk1("hold_c4_busy", busy, 1'b0);
        step();
        store_req = 1'b0;
        chk1("hold_c5_rd", mem_rd_en, 1'b1);
        step();
        step();
        chk1("hold_c7_wr", mem_wr_en, 1'b1);
        chk32("hold_c7_wdata", mem_wdata, 32'h1122AB44);
        step();
        step();
        step();
        idle_outputs("hold_end");
        chk32("hold_writes", 32'(wr_count - base), 32'd2);

        // back-to-back sw
        addr = 32'h104; funct3 = 3'b010; write_data = 32'h00000001;
        store_req = 1'b1;
        step();
        chk1("b2b_c1_wr", mem_wr_en, 1'b1);
        chk32("b2b_c1_wdata", mem_wdata, 32'h00000001);
        addr = 32'h108; write_data = 32'h00000002;
        step();
        chk1("b2b_c2_wr", mem_wr_en, 1'b0);
        chk1("b2b_c2_busy", busy, 1'b0);
        step();
        store_req = 1'b0;
        chk1("b2b_c3_wr", mem_wr_en, 1'b1);
        chk32("b2b_c3_addr", mem_addr, 32'h108);
        chk32("b2b_c3_wdata", mem_wdata, 32'h00000002);
        step();
        idle_outputs("b2b_c4");

        // reset during MERGE
        mem_word = 32'h11223344;
        addr = 32'h200; funct3 = 3'b000; write_data = 32'h000000AB;
        store_req = 1'b1;
        step();
        store_req = 1'b0;
        step();
        chk1("rst_c2_busy", busy, 1'b1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        base = wr_count;
        idle_outputs("rst_c3");
        chk1("rst_c3_err", misaligned_err, 1'b0);
        step();
        chk1("rst_c4_done", done, 1'b0);
        chk1("rst_c4_wr", mem_wr_en, 1'b0);
        step();
        chk32("rst_writes", 32'(wr_count - base), 32'd0);

        // reset and request together: reset wins
        reset = 1'b1; store_req = 1'b1;
        addr = 32'h100; funct3 = 3'b010; write_data = 32'hCAFEF00D;
        step();
        reset = 1'b0; store_req = 1'b0;
        idle_outputs("rst_req_c1");
        step();
        idle_outputs("rst_req_c2");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
